ff_bank: RTL and testbench

FF_BANK -- requirements
Module: ff_bank

---
 rtl/ff_bank_pkg.sv | 20 ++
 rtl/ff_cell.sv | 62 ++++++
 rtl/ff_bank.sv | 102 ++++++++++
 tb/tb_ff_bank.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg -- shared definitions for the ff_bank flip-flop bank.
//   Mode encodings (MODE_SR, MODE_JK, MODE_D, MODE_T).
//   Default channel count and illegal-event counter width.
//   A helper that decodes the illegal SR input combination.
package ff_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

  // S and R asserted together in SR mode is the only illegal input combination.
  function automatic logic is_illegal(input logic [1:0] mode, input logic a, input logic b);
    return (mode == MODE_SR) && a && b;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// ff_cell -- one configurable SR/JK/D/T flip-flop channel.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset (q -> 0)
//   en_i      : update enable
//   mode_i    : channel mode (SR/JK/D/T)
//   a_i, b_i  : S/J/D/T and R/K inputs
//   q_o       : registered state
//   illegal_o : combinational strobe, high when this channel sees an
//               enabled illegal SR input this cycle
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       q_o,
  output logic       illegal_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (mode_i)
      MODE_SR: begin
        // 11 is illegal: keep state rather than produce an unknown value
        case ({a_i, b_i})
          2'b01:   q_d = 1'b0;
          2'b10:   q_d = 1'b1;
          default: q_d = q_q;
        endcase
      end
      MODE_JK: begin
        case ({a_i, b_i})
          2'b01:   q_d = 1'b0;
          2'b10:   q_d = 1'b1;
          2'b11:   q_d = ~q_q;
          default: q_d = q_q;
        endcase
      end
      MODE_D:  q_d = a_i;
      default: q_d = a_i ? ~q_q : q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o       = q_q;
  assign illegal_o = en_i && is_illegal(mode_i, a_i, b_i);

endmodule

// File: rtl/ff_bank.sv
// ff_bank -- WIDTH independent SR/JK/D/T flip-flops sharing one mode,
// with sticky per-channel illegal-input flags.
// Optional feature macro: FF_BANK_ERR_CNT_EN adds the saturating
// illegal-cycle counter err_cnt (and parameter CNT_W).
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   en       : update enable (clr_err still acts when low)
//   mode     : shared mode 00 SR, 01 JK, 10 D, 11 T
//   a, b     : per-channel inputs
//   clr_err  : clears err (and err_cnt)
//   q, qn    : channel state and its complement
//   err      : sticky illegal flags
//   err_cnt  : saturating count of cycles with any illegal channel
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef FF_BANK_ERR_CNT_EN
  , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err
`ifdef FF_BANK_ERR_CNT_EN
  , output logic [CNT_W-1:0] err_cnt
`endif
);

  logic [WIDTH-1:0] illegal_vec;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] err_d;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      ff_cell u_cell (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en),
        .mode_i    (mode),
        .a_i       (a[gi]),
        .b_i       (b[gi]),
        .q_o       (q[gi]),
        .illegal_o (illegal_vec[gi])
      );
    end
  endgenerate

  assign qn = ~q;

  // Clear first, then OR in new events so a same-edge illegal input wins.
  assign err_d = (clr_err ? '0 : err_q) | illegal_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef FF_BANK_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             any_illegal;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign any_illegal = |illegal_vec;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      // An illegal cycle coinciding with the clear is counted as the first one.
      cnt_d = any_illegal ? CNT_W'(1) : '0;
    end else if (any_illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ff_bank.sv
module tb_ff_bank;
  import ff_bank_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = MODE_D;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       clr_err = 1'b0;
  logic [7:0] q;
  logic [7:0] qn;
  logic [7:0] err;
`ifdef FF_BANK_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_bank #(
    .WIDTH (8)
`ifdef FF_BANK_ERR_CNT_EN
    , .CNT_W (8)
`endif
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .clr_err (clr_err),
    .q       (q),
    .qn      (qn),
    .err     (err)
`ifdef FF_BANK_ERR_CNT_EN
    , .err_cnt (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] av,
                       input logic [7:0] bv, input logic c);
    en = e; mode = m; a = av; b = bv; clr_err = c;
  endtask

  initial begin
    @(negedge clk);
    // Reset overrides en, mode and clr_err
    drive(1'b1, MODE_D, 8'hFF, 8'h00, 1'b1);
    reset = 1'b1;
    tick(1);
    check("reset_q", 32'(q), 32'h00);
    check("reset_qn", 32'(qn), 32'hFF);
    check("reset_err", 32'(err), 32'h00);
`ifdef FF_BANK_ERR_CNT_EN
    check("reset_cnt", 32'(err_cnt), 32'd0);
`endif
    // First update at the edge where reset is sampled low
    reset = 1'b0;
    drive(1'b1, MODE_D, 8'hB4, 8'hFF, 1'b0);
    tick(1);
    check("d_load", 32'(q), 32'hB4);

    // SR: 7:6 hold(10), 5:4 reset, 3:2 illegal hold(01), 1:0 set
    drive(1'b1, MODE_SR, 8'h0F, 8'h3C, 1'b0);
    tick(1);
    check("sr_q", 32'(q), 32'h87);
    check("sr_qn", 32'(qn), 32'h78);
    check("sr_err", 32'(err), 32'h0C);
`ifdef FF_BANK_ERR_CNT_EN
    check("sr_cnt", 32'(err_cnt), 32'd1);
`endif

    // Clear acts while disabled; q holds
    drive(1'b0, MODE_D, 8'h00, 8'h00, 1'b1);
    tick(1);
    check("clr_en0_q", 32'(q), 32'h87);
    check("clr_en0_err", 32'(err), 32'h00);
`ifdef FF_BANK_ERR_CNT_EN
    check("clr_en0_cnt", 32'(err_cnt), 32'd0);
`endif

    // JK toggling from 00
    drive(1'b1, MODE_D, 8'h00, 8'h00, 1'b0);
    tick(1);
    drive(1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0);
    tick(1);
    check("jk_t1", 32'(q), 32'hFF);
    tick(1);
    check("jk_t2", 32'(q), 32'h00);
    tick(1);
    check("jk_t3", 32'(q), 32'hFF);
    check("jk_err", 32'(err), 32'h00);
    drive(1'b1, MODE_JK, 8'h0F, 8'hF0, 1'b0);
    tick(1);
    check("jk_set_reset", 32'(q), 32'h0F);

    // T mode with en 1,0,1
    drive(1'b1, MODE_D, 8'h00, 8'h00, 1'b0);
    tick(1);
    drive(1'b1, MODE_T, 8'h01, 8'hFF, 1'b0);
    tick(1);
    check("t_en1", 32'(q), 32'h01);
    en = 1'b0;
    tick(1);
    check("t_en0", 32'(q), 32'h01);
    en = 1'b1;
    tick(1);
    check("t_en1b", 32'(q), 32'h00);

    // Mode change takes effect immediately
    drive(1'b1, MODE_D, 8'hAA, 8'h00, 1'b0);
    tick(1);
    check("mode_d", 32'(q), 32'hAA);
    drive(1'b1, MODE_T, 8'h0F, 8'h00, 1'b0);
    tick(1);
    check("mode_t", 32'(q), 32'hA5);

    // Reset mid-operation discards a pending toggle
    drive(1'b1, MODE_T, 8'hFF, 8'h00, 1'b0);
    reset = 1'b1;
    tick(1);
    check("midrst_q", 32'(q), 32'h00);
    reset = 1'b0;
    drive(1'b0, MODE_T, 8'h00, 8'h00, 1'b0);
    tick(1);
    check("midrst_hold", 32'(q), 32'h00);

    // Set wins over clear on the same edge
    drive(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0);
    tick(1);
    check("err_set", 32'(err), 32'h01);
    drive(1'b1, MODE_SR, 8'h02, 8'h02, 1'b1);
    tick(1);
    check("err_setwins", 32'(err), 32'h02);
`ifdef FF_BANK_ERR_CNT_EN
    check("cnt_setwins", 32'(err_cnt), 32'd1);
`endif

    // Illegal held: counter saturates, q holds
    drive(1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b0);
    tick(253);
`ifdef FF_BANK_ERR_CNT_EN
    check("cnt_254", 32'(err_cnt), 32'd254);
`endif
    tick(47);
    check("ill_q", 32'(q), 32'h00);
    check("ill_err", 32'(err), 32'hFF);
`ifdef FF_BANK_ERR_CNT_EN
    check("cnt_sat", 32'(err_cnt), 32'd255);
`endif
    clr_err = 1'b1;
    tick(1);
    check("clr_ill_err", 32'(err), 32'hFF);
`ifdef FF_BANK_ERR_CNT_EN
    check("cnt_clr_ill", 32'(err_cnt), 32'd1);
`endif
    // Disabled: illegal inputs ignored, state holds
    drive(1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b0);
    tick(2);
    check("en0_err", 32'(err), 32'hFF);
`ifdef FF_BANK_ERR_CNT_EN
    check("en0_cnt", 32'(err_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
